// File: rtl/tcp_vlg_rx_buf.sv
// tcp_vlg_rx_buf: receive-side TCP payload buffer.
// In-order payload bytes are written into a ring indexed by sequence number.
// A segment is only committed (ack advanced) when it ends with a good checksum.
// Committed bytes are streamed to the user through a first-word-fall-through
// output register. Free space is reported as the receive window.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | between segments, waiting for a start-of-segment beat
// RECV  | accepted segment in progress, bytes written at wr
// DROP  | rejected segment in progress, bytes discarded until eof
module tcp_vlg_rx_buf #(
  parameter int D = 16,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic [31:0]  init_seq,
  input  logic         seg_val,
  input  logic         seg_sof,
  input  logic         seg_eof,
  input  logic         seg_err,
  input  logic [31:0]  seg_seq,
  input  logic [W-1:0] seg_dat,
  output logic [31:0]  ack,
  output logic [D-1:0] space,
  output logic         drop,
  output logic [W-1:0] dout,
  output logic         dout_val,
  input  logic         dout_rdy,
  output logic         e,
  output logic         f
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  localparam logic [D-1:0] ONE_D  = 1;
  localparam logic [D:0]   MAX_SP = {1'b0, {D{1'b1}}};

  logic [W-1:0] mem [2**D];

  logic [1:0]   state, state_n;
  logic [31:0]  rd, rd_n, rd_p1;
  logic [31:0]  wr, wr_n;
  logic [31:0]  ack_n;
  logic [D-1:0] cnt, cnt_n;
  logic [D-1:0] space_n;
  logic [D:0]   used_n;
  logic         drop_n;
  logic         we;
  logic [D-1:0] waddr;
  logic         pop;
  logic         rd_avail;
  logic         rd_issue;
  logic [D-1:0] raddr;

  // Read side: decide whether the output register is refilled this cycle
  always_comb begin
    pop      = dout_val & dout_rdy;
    rd_p1    = rd + 32'd1;
    rd_avail = pop ? (ack != rd_p1) : (ack != rd);
    rd_issue = (!dout_val || pop) && rd_avail && !init;
    raddr    = pop ? rd_p1[D-1:0] : rd[D-1:0];
    rd_n     = init ? init_seq : (pop ? rd_p1 : rd);
  end

  // Segment FSM: write/commit/drop decisions and next pointer values
  always_comb begin
    state_n = state;
    ack_n   = ack;
    wr_n    = wr;
    cnt_n   = cnt;
    drop_n  = 1'b0;
    we      = 1'b0;
    waddr   = wr[D-1:0];
    if (init) begin
      ack_n   = init_seq;
      state_n = S_IDLE;
    end else if (seg_val) begin
      if (seg_sof) begin
        // A new sof abandons any segment still open; the new one is judged fresh.
        if (state != S_IDLE) drop_n = 1'b1;
        if (seg_seq == ack && space != '0) begin
          we    = 1'b1;
          waddr = ack[D-1:0];
          wr_n  = ack + 32'd1;
          cnt_n = ONE_D;
          if (seg_eof) begin
            state_n = S_IDLE;
            if (seg_err) drop_n = 1'b1;
            else         ack_n  = ack + 32'd1;
          end else begin
            state_n = S_RECV;
          end
        end else if (seg_eof) begin
          drop_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          state_n = S_DROP;
        end
      end else if (state == S_RECV) begin
        // Bytes beyond the free space are silently truncated.
        if (cnt < space) begin
          we    = 1'b1;
          wr_n  = wr + 32'd1;
          cnt_n = cnt + ONE_D;
        end
        if (seg_eof) begin
          state_n = S_IDLE;
          if (seg_err) drop_n = 1'b1;
          else         ack_n  = ack + 32'(cnt_n);
        end
      end else if (state == S_DROP) begin
        if (seg_eof) begin
          drop_n  = 1'b1;
          state_n = S_IDLE;
        end
      end
    end
    used_n  = (D+1)'(ack_n - rd_n);
    space_n = D'(MAX_SP - used_n);
  end

  // Payload RAM write port
  always_ff @(posedge clk) begin
    if (we && !rst) mem[waddr] <= seg_dat;
  end

  // Registered pointers, window, drop pulse and output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ack      <= '0;
      rd       <= '0;
      wr       <= '0;
      cnt      <= '0;
      space    <= MAX_SP[D-1:0];
      drop     <= 1'b0;
      dout     <= '0;
      dout_val <= 1'b0;
    end else begin
      state <= state_n;
      ack   <= ack_n;
      rd    <= rd_n;
      wr    <= wr_n;
      cnt   <= cnt_n;
      space <= space_n;
      drop  <= drop_n;
      if (init)          dout_val <= 1'b0;
      else if (rd_issue) dout_val <= 1'b1;
      else if (pop)      dout_val <= 1'b0;
      if (rd_issue) dout <= mem[raddr];
    end
  end

  assign e = (ack == rd);
  assign f = (space[D-1:1] == '0);

endmodule

// File: tb/tb_tcp_vlg_rx_buf.sv
// Directed bench for tcp_vlg_rx_buf with a 16-word ring (D=4).
module tb_tcp_vlg_rx_buf;

  localparam int D = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         init;
  logic [31:0]  init_seq;
  logic         seg_val, seg_sof, seg_eof, seg_err;
  logic [31:0]  seg_seq;
  logic [W-1:0] seg_dat;
  logic [31:0]  ack;
  logic [D-1:0] space;
  logic         drop;
  logic [W-1:0] dout;
  logic         dout_val;
  logic         dout_rdy;
  logic         e, f;

  int n_chk = 0;
  int n_err = 0;

  tcp_vlg_rx_buf #(.D(D), .W(W)) dut (
    .clk(clk), .rst(rst), .init(init), .init_seq(init_seq),
    .seg_val(seg_val), .seg_sof(seg_sof), .seg_eof(seg_eof), .seg_err(seg_err),
    .seg_seq(seg_seq), .seg_dat(seg_dat), .ack(ack), .space(space), .drop(drop),
    .dout(dout), .dout_val(dout_val), .dout_rdy(dout_rdy), .e(e), .f(f)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic sof, input logic eof, input logic err,
                      input logic [31:0] seq, input logic [7:0] dat);
    seg_val = 1'b1; seg_sof = sof; seg_eof = eof; seg_err = err;
    seg_seq = seq; seg_dat = dat;
    step();
    seg_val = 1'b0; seg_sof = 1'b0; seg_eof = 1'b0; seg_err = 1'b0;
  endtask

  task automatic send_seg(input logic [31:0] seq, input int n, input logic [7:0] base,
                          input logic err);
    for (int i = 0; i < n; i++)
      beat(i == 0, i == n - 1, (i == n - 1) && err, seq, base + 8'(i));
  endtask

  task automatic do_init(input logic [31:0] s);
    init = 1'b1; init_seq = s;
    step();
    init = 1'b0;
  endtask

  task automatic drain(input string tag, input int n, input logic [7:0] base);
    dout_rdy = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_val"}, 32'(dout_val), 32'd1);
      chk({tag, "_dat"}, 32'(dout), 32'(base + 8'(i)));
      step();
    end
    dout_rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; init = 1'b0; init_seq = '0;
    seg_val = 1'b0; seg_sof = 1'b0; seg_eof = 1'b0; seg_err = 1'b0;
    seg_seq = '0; seg_dat = '0; dout_rdy = 1'b0;
    step(); step();
    chk("rst_ack",   ack,            32'h0);
    chk("rst_space", 32'(space),     32'd15);
    chk("rst_e",     32'(e),         32'd1);
    chk("rst_f",     32'(f),         32'd0);
    chk("rst_dval",  32'(dout_val),  32'd0);
    chk("rst_drop",  32'(drop),      32'd0);
    chk("rst_dout",  32'(dout),      32'd0);
    rst = 1'b0;
    step();

    // good 5-byte segment
    do_init(32'h1000);
    chk("init_ack", ack, 32'h1000);
    send_seg(32'h1000, 5, 8'hA0, 1'b0);
    chk("t1_ack",   ack,         32'h1005);
    chk("t1_space", 32'(space),  32'd10);
    chk("t1_drop",  32'(drop),   32'd0);
    chk("t1_e",     32'(e),      32'd0);
    step();
    drain("t1", 5, 8'hA0);
    chk("t1_dval_end",  32'(dout_val), 32'd0);
    chk("t1_e_end",     32'(e),        32'd1);
    chk("t1_space_end", 32'(space),    32'd15);

    // out-of-order segment rejected
    send_seg(32'h1008, 3, 8'h30, 1'b0);
    chk("t2_drop", 32'(drop), 32'd1);
    chk("t2_ack",  ack,       32'h1005);
    step();
    chk("t2_drop_end", 32'(drop),  32'd0);
    chk("t2_space",    32'(space), 32'd15);

    // checksum error at eof
    send_seg(32'h1005, 5, 8'h40, 1'b1);
    chk("t3_drop", 32'(drop), 32'd1);
    chk("t3_ack",  ack,       32'h1005);
    step();
    chk("t3_drop_end", 32'(drop),     32'd0);
    chk("t3_dval",     32'(dout_val), 32'd0);
    chk("t3_e",        32'(e),        32'd1);

    // overfill: 20 bytes into 15 free words, truncated
    send_seg(32'h1005, 20, 8'h10, 1'b0);
    chk("t4_ack",   ack,        32'h1014);
    chk("t4_space", 32'(space), 32'd0);
    chk("t4_f",     32'(f),     32'd1);
    chk("t4_drop",  32'(drop),  32'd0);
    step(); step();
    chk("t4_space_held", 32'(space), 32'd0);
    drain("t4", 15, 8'h10);
    chk("t4_dval_end",  32'(dout_val), 32'd0);
    chk("t4_space_end", 32'(space),    32'd15);
    chk("t4_f_end",     32'(f),        32'd0);

    // sequence wrap
    do_init(32'hFFFF_FFFE);
    chk("t5_init_ack", ack, 32'hFFFF_FFFE);
    send_seg(32'hFFFF_FFFE, 4, 8'hC0, 1'b0);
    chk("t5_ack",   ack,        32'h0000_0002);
    chk("t5_space", 32'(space), 32'd11);
    step();
    drain("t5", 4, 8'hC0);
    chk("t5_e_end", 32'(e), 32'd1);

    // sof in the middle of a segment abandons it
    beat(1'b1, 1'b0, 1'b0, 32'h2, 8'h50);
    beat(1'b0, 1'b0, 1'b0, 32'h0, 8'h51);
    beat(1'b0, 1'b0, 1'b0, 32'h0, 8'h52);
    chk("t6_drop_pre", 32'(drop), 32'd0);
    beat(1'b1, 1'b0, 1'b0, 32'h2, 8'h60);
    chk("t6_drop", 32'(drop), 32'd1);
    chk("t6_ack_mid", ack, 32'h2);
    beat(1'b0, 1'b1, 1'b0, 32'h0, 8'h61);
    chk("t6_drop_end", 32'(drop), 32'd0);
    chk("t6_ack", ack, 32'h4);
    step();
    drain("t6", 2, 8'h60);
    chk("t6_dval_end", 32'(dout_val), 32'd0);
    chk("t6_space_end", 32'(space), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/tcp_vlg_rx_buf.md
# tcp_vlg_rx_buf

Receive-side TCP payload buffer. Sits between the TCP segment parser and the user receive stream. Accepts payload bytes of incoming segments, stores in-order data in a ring memory indexed by sequence number, and commits it (advances the local acknowledgement number) only when the segment ends with a good checksum. It presents committed bytes to the user over a valid/ready stream and reports the free space used as the advertised receive window.

## Interface
Parameters:
- D, 16, log2 of buffer depth in words; usable capacity 2^D-1
- W, 8, data word width (one TCP payload byte)

Ports (tcp_num_t is the 32-bit TCP sequence type):
- clk  input  1  clock; single clock domain
- rst  input  1  reset; synchronous, active-high
- init  input  1  pulse; load initial expected sequence number
- init_seq  input  tcp_num_t  remote ISN+1, sampled when init=1
- seg_val  input  1  payload byte valid
- seg_sof  input  1  first byte of segment, qualified by seg_val
- seg_eof  input  1  last byte of segment, qualified by seg_val
- seg_err  input  1  checksum/format error, sampled with seg_eof
- seg_seq  input  tcp_num_t  sequence number of first byte, sampled with seg_sof
- seg_dat  input  W  payload byte
- ack  output  tcp_num_t  next expected remote sequence number (committed)
- space  output  D  free words (receive window)
- drop  output  1  one-cycle pulse: segment discarded
- dout  output  W  user data
- dout_val  output  1  dout holds a committed byte
- dout_rdy  input  1  user accepts dout
- e  output  1  no committed unread data
- f  output  1  space <= 1

## Operation
- Memory: 2^D x W, synchronous read, write address = sequence[D-1:0].
- Pointers: ack (commit), wr (write sequence), rd (sequence of byte in dout, or next byte if dout empty); all tcp_num_t, wrap modulo 2^32.
- used = (ack - rd)[D:0]; space = 2^D-1-used; e = (ack == rd); f = (space[D-1:1] == 0).
- init: ack<=init_seq, rd<=init_seq, dout_val<=0, state<=IDLE; overrides any other event that cycle, aborts a segment in progress (no commit, no drop pulse).
- States: IDLE, RECV, DROP.
- IDLE, seg_val&seg_sof: accept if seg_seq==ack and space!=0; else reject.
  - accept: write byte at ack, wr<=ack+1, cnt<=1; go RECV (if seg_eof same cycle, commit directly, stay IDLE).
  - reject: go DROP (if seg_eof same cycle, pulse drop, stay IDLE).
- IDLE, seg_val without seg_sof: ignored.
- RECV, seg_val: if cnt<space write at wr, wr++, cnt++; else byte discarded (truncation, legal in TCP).
- RECV, seg_val&seg_eof: if !seg_err, ack<=ack+cnt; else pulse drop, ack unchanged. Go IDLE.
- RECV or DROP, seg_val&seg_sof without preceding eof: current segment abandoned (no commit, drop pulse), new segment evaluated as from IDLE same cycle.
- DROP, seg_val&seg_eof: pulse drop, go IDLE. No writes in DROP.
- Bytes written but not committed are never visible to the reader and are overwritten by the next accepted segment.
- Read side: first-word-fall-through. When dout_val=0 or (dout_val&dout_rdy), and committed data beyond the byte being popped exists, issue RAM read; dout_val asserts next cycle. Pop (dout_val&dout_rdy) advances rd and frees one word.
- space counts words still held in dout as used.

## Timing
- Reset values: ack=0, rd=0, wr=0, space=2^D-1, dout=0, dout_val=0, drop=0, e=1, f=0, state IDLE.
- ack update: registered, visible the cycle after the eof beat.
- Read latency: byte committed with ack visible at cycle N -> dout_val earliest at N+1.
- Sustained throughput: one write and one pop per cycle simultaneously.
- space update: registered arithmetic from ack/rd, same cycle as pointer change.
- drop: asserted exactly one cycle, the cycle after the terminating beat.
- Simultaneous commit and pop: both applied; space = old space - cnt + 1.
- Sequence wrap 0xFFFFFFFF->0: no special handling; modular arithmetic.
- Reset mid-segment: all state cleared; parser beats until next init are processed against ack=0.

## Test plan
- D=4, init_seq=0x1000; 5-byte segment seq=0x1000 good -> ack=0x1005 cycle after eof, space=10, dout emits 5 bytes in order, then e=1, space=15.
- Segment seq=0x1003 while ack=0x1000 -> no writes, drop pulse one cycle after eof, ack unchanged.
- 5-byte segment with seg_err=1 at eof -> ack unchanged, drop pulse, dout_val stays 0.
- D=4, dout_rdy=0, 20-byte good segment from empty -> 15 bytes committed, ack+=15, space=0, f=1; then dout_rdy=1 drains all 15, space=15.
- init_seq=0xFFFFFFFE, 4-byte good segment -> ack=0x00000002, bytes read out in order across wrap.
- sof arrives mid-RECV without eof -> first segment abandoned with drop pulse, second (seq==ack) committed normally.
